freq_gate_ctrl: RTL and testbench

Measurement-window controller for the frequency meter, upstream of the 6-digit BCD event counter.
- Drives the counter's ENA and CLR, and times a fixed gate window from the reference clock.
- After the window closes and the counter has frozen, latches the counter's 24-bit BCD result.
- Raises a one-cycle VALID pulse for the display/readout stage.

---
 rtl/freq_gate_ctrl.sv | 133 +++++++++++++
 tb/tb_freq_gate_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// Gate-window controller for the frequency meter: clears and enables the BCD
// event counter, waits for it to freeze, then captures its count.
module freq_gate_ctrl #(
  parameter int GATE_CYCLES   = 50000000,
  parameter int CLR_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int TMR_W         = 26
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN,
  input  logic [23:0] Q_IN,
  output logic        ENA,
  output logic        CLR,
  output logic [23:0] RESULT,
  output logic        VALID,
  output logic        DIGIT_ERR,
  output logic        BUSY,
  output logic [2:0]  state_dbg_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_LOAD   = 3'd4
  } state_t;

  localparam logic [TMR_W-1:0] CLR_LAST    = TMR_W'(CLR_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              ena_q, ena_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [23:0]       result_q, result_d;
  logic              derr_q, derr_d;
  logic              capture;

  function automatic logic has_bad_digit(input logic [23:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TMR_W'(1);
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (RUN) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (tmr_q == CLR_LAST) begin
          state_d = S_GATE;
          tmr_d   = '0;
        end
      end
      S_GATE: begin
        if (tmr_q == GATE_LAST) begin
          state_d = S_SETTLE;
          tmr_d   = '0;
        end
      end
      S_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = S_LOAD;
          tmr_d   = '0;
        end
      end
      S_LOAD: begin
        tmr_d   = '0;
        capture = 1'b1;
        state_d = RUN ? S_CLEAR : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  // while staying free of any input-to-output combinational path.
  always_comb begin
    ena_d    = (state_d == S_GATE);
    clr_d    = (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_LOAD);
    busy_d   = (state_d != S_IDLE);
    valid_d  = capture;
    result_d = capture ? Q_IN : result_q;
    derr_d   = capture ? has_bad_digit(Q_IN) : derr_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      ena_q    <= 1'b0;
      clr_q    <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      ena_q    <= ena_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      derr_q   <= derr_d;
    end
  end

  assign ENA         = ena_q;
  assign CLR         = clr_q;
  assign BUSY        = busy_q;
  assign VALID       = valid_q;
  assign RESULT      = result_q;
  assign DIGIT_ERR   = derr_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl with a short gate (10/2/3 cycles, 16-cycle period);
// captured {DIGIT_ERR, RESULT} pairs are scoreboarded against expected values.
module tb_freq_gate_ctrl;

  localparam int GATE   = 10;
  localparam int CLRN   = 2;
  localparam int SETTLE = 3;
  localparam int PERIOD = CLRN + GATE + SETTLE + 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        RUN = 1'b0;
  logic [23:0] Q_IN = '0;
  logic        ENA, CLR, VALID, DIGIT_ERR, BUSY;
  logic [23:0] RESULT;
  logic [2:0]  state_dbg;

  int checks = 0;
  int passed = 0;

  logic [24:0] exp_q[$];
  logic [24:0] got_q[$];

  // per-observation statistics
  int ena_cnt, clr_low_cnt, valid_cnt, overlap_cnt, gap_bad;
  int first_ena, first_valid, last_valid;
  logic busy_at0;

  freq_gate_ctrl #(
    .GATE_CYCLES(GATE), .CLR_CYCLES(CLRN), .SETTLE_CYCLES(SETTLE), .TMR_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .Q_IN(Q_IN),
    .ENA(ENA), .CLR(CLR), .RESULT(RESULT), .VALID(VALID),
    .DIGIT_ERR(DIGIT_ERR), .BUSY(BUSY), .state_dbg_o(state_dbg)
  );

  always #5 CLK = ~CLK;

  function automatic logic bcd_bad(input logic [23:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 6; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic logic [23:0] rand_bcd();
    logic [23:0] v;
    for (int i = 0; i < 6; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Drive a new Q_IN value and record the capture it should produce.
  task automatic drive_q(input logic [23:0] v);
    Q_IN = v;
    exp_q.push_back({bcd_bad(v), v});
  endtask

  // Called at a negedge with inputs set; step k samples after the k-th edge
  // (k=0 is the edge on which IDLE sees RUN).
  task automatic observe(input int n, input int drop_at, input int reloads);
    int left;
    left = reloads;
    ena_cnt = 0; clr_low_cnt = 0; valid_cnt = 0; overlap_cnt = 0; gap_bad = 0;
    first_ena = -1; first_valid = -1; last_valid = -1; busy_at0 = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (k == 0) busy_at0 = BUSY;
      if (ENA) ena_cnt++;
      if (!CLR) clr_low_cnt++;
      if (ENA && CLR) overlap_cnt++;
      if (ENA && first_ena < 0) first_ena = k;
      if (VALID) begin
        if (last_valid >= 0 && (k - last_valid) != PERIOD) gap_bad++;
        if (first_valid < 0) first_valid = k;
        last_valid = k;
        valid_cnt++;
        got_q.push_back({DIGIT_ERR, RESULT});
        if (left > 0) begin
          left--;
          drive_q(rand_bcd());
        end
      end
      if (k == drop_at) RUN = 1'b0;
    end
  endtask

  task automatic test_reset();
    RUN = 1'b1;
    #1 RST = 1'b1;
    #1;
    checks++; if (ENA !== 1'b0) $display("FAIL reset_ena got=%b exp=0", ENA); else passed++;
    checks++; if (CLR !== 1'b1) $display("FAIL reset_clr got=%b exp=1", CLR); else passed++;
    checks++; if (RESULT !== 24'h0) $display("FAIL reset_result got=%h exp=000000", RESULT); else passed++;
    checks++; if (VALID !== 1'b0) $display("FAIL reset_valid got=%b exp=0", VALID); else passed++;
    checks++; if (DIGIT_ERR !== 1'b0) $display("FAIL reset_derr got=%b exp=0", DIGIT_ERR); else passed++;
    checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", BUSY); else passed++;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RUN = 1'b0;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (BUSY !== 1'b0 || CLR !== 1'b1) $display("FAIL idle_after_reset busy=%b clr=%b exp busy=0 clr=1", BUSY, CLR); else passed++;
  endtask

  task automatic test_single();
    logic [24:0] e, g;
    drive_q(24'h000123);
    RUN = 1'b1;
    observe(PERIOD + 5, 0, 0);
    checks++; if (busy_at0 !== 1'b1) $display("FAIL single_busy_start got=%b exp=1", busy_at0); else passed++;
    checks++; if (first_ena != CLRN) $display("FAIL single_first_ena got=%0d exp=%0d", first_ena, CLRN); else passed++;
    checks++; if (ena_cnt != GATE) $display("FAIL single_ena_cycles got=%0d exp=%0d", ena_cnt, GATE); else passed++;
    checks++; if (clr_low_cnt != GATE + SETTLE) $display("FAIL single_clr_low got=%0d exp=%0d", clr_low_cnt, GATE + SETTLE); else passed++;
    checks++; if (valid_cnt != 1) $display("FAIL single_valid_cnt got=%0d exp=1", valid_cnt); else passed++;
    checks++; if (first_valid != PERIOD) $display("FAIL single_valid_at got=%0d exp=%0d", first_valid, PERIOD); else passed++;
    checks++; if (BUSY !== 1'b0 || CLR !== 1'b1 || ENA !== 1'b0) $display("FAIL single_end_idle busy=%b clr=%b ena=%b exp 0/1/0", BUSY, CLR, ENA); else passed++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL single_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) $display("FAIL single_capture got=%h exp=%h", g, e); else passed++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_continuous();
    logic [24:0] e, g;
    drive_q(rand_bcd());
    RUN = 1'b1;
    observe(5 * PERIOD + 6, 4 * PERIOD + 6, 4);
    checks++; if (valid_cnt != 5) $display("FAIL cont_valid_cnt got=%0d exp=5", valid_cnt); else passed++;
    checks++; if (gap_bad != 0) $display("FAIL cont_valid_spacing bad_gaps=%0d exp=0", gap_bad); else passed++;
    checks++; if (overlap_cnt != 0) $display("FAIL cont_ena_with_clr got=%0d exp=0", overlap_cnt); else passed++;
    checks++; if (ena_cnt != 5 * GATE) $display("FAIL cont_ena_cycles got=%0d exp=%0d", ena_cnt, 5 * GATE); else passed++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL cont_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) $display("FAIL cont_capture got=%h exp=%h", g, e); else passed++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stop_mid_gate();
    logic [24:0] e, g;
    drive_q(rand_bcd());
    RUN = 1'b1;
    // gate cycle 4 is step CLRN+3
    observe(PERIOD + 6, CLRN + 3, 0);
    checks++; if (ena_cnt != GATE) $display("FAIL stop_ena_cycles got=%0d exp=%0d", ena_cnt, GATE); else passed++;
    checks++; if (valid_cnt != 1) $display("FAIL stop_valid_cnt got=%0d exp=1", valid_cnt); else passed++;
    checks++; if (BUSY !== 1'b0 || CLR !== 1'b1) $display("FAIL stop_end_idle busy=%b clr=%b exp busy=0 clr=1", BUSY, CLR); else passed++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL stop_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) $display("FAIL stop_capture got=%h exp=%h", g, e); else passed++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_invalid_bcd();
    logic [24:0] e, g;
    drive_q(24'h0000A5);
    RUN = 1'b1;
    observe(PERIOD + 3, 0, 0);
    checks++; if (DIGIT_ERR !== 1'b1 || RESULT !== 24'h0000A5) $display("FAIL bcd_bad_capture got=%b/%h exp=1/0000a5", DIGIT_ERR, RESULT); else passed++;
    drive_q(24'h999999);
    RUN = 1'b1;
    observe(PERIOD + 3, 0, 0);
    checks++; if (DIGIT_ERR !== 1'b0 || RESULT !== 24'h999999) $display("FAIL bcd_max_capture got=%b/%h exp=0/999999", DIGIT_ERR, RESULT); else passed++;
    // RESULT holds while idle even with Q_IN moving
    Q_IN = 24'h000555;
    repeat (4) @(negedge CLK);
    checks++; if (RESULT !== 24'h999999) $display("FAIL result_hold got=%h exp=999999", RESULT); else passed++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL bcd_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) $display("FAIL bcd_capture got=%h exp=%h", g, e); else passed++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_op();
    logic [24:0] e, g;
    drive_q(rand_bcd());
    RUN = 1'b1;
    // stop sampling in gate cycle 5 (step CLRN+4)
    observe(CLRN + 5, -1, 0);
    checks++; if (ENA !== 1'b1) $display("FAIL rmid_in_gate got=%b exp=1", ENA); else passed++;
    RST = 1'b1;
    #1;
    checks++; if (ENA !== 1'b0 || CLR !== 1'b1) $display("FAIL rmid_async ena=%b clr=%b exp ena=0 clr=1", ENA, CLR); else passed++;
    checks++; if (RESULT !== 24'h0 || DIGIT_ERR !== 1'b0) $display("FAIL rmid_result got=%h/%b exp=000000/0", RESULT, DIGIT_ERR); else passed++;
    checks++; if (VALID !== 1'b0 || BUSY !== 1'b0) $display("FAIL rmid_valid_busy valid=%b busy=%b exp 0/0", VALID, BUSY); else passed++;
    RST = 1'b0;
    got_q.delete(); exp_q.delete();
    drive_q(rand_bcd());
    observe(PERIOD + 4, CLRN + 1, 0);
    checks++; if (busy_at0 !== 1'b1) $display("FAIL rmid_restart_busy got=%b exp=1", busy_at0); else passed++;
    checks++; if (ena_cnt != GATE) $display("FAIL rmid_ena_cycles got=%0d exp=%0d", ena_cnt, GATE); else passed++;
    checks++; if (first_valid != PERIOD || valid_cnt != 1) $display("FAIL rmid_valid at=%0d cnt=%0d exp at=%0d cnt=1", first_valid, valid_cnt, PERIOD); else passed++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL rmid_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) $display("FAIL rmid_capture got=%h exp=%h", g, e); else passed++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    @(negedge CLK);
    test_single();
    @(negedge CLK);
    test_continuous();
    @(negedge CLK);
    test_stop_mid_gate();
    @(negedge CLK);
    test_invalid_bcd();
    @(negedge CLK);
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
